// File: rtl/spi_master_scheduler_pkg.sv
// Shared definitions for the SPI master scheduler: FSM encoding, SPI mode and byte width.
package spi_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_XFER  = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    localparam int BYTE_W = 8;

endpackage

// File: rtl/spi_master_scheduler_rr_arbiter.sv
// Round-robin picker: first set request at or after the pointer, wrapping; pointer moves past the winner.
module spi_rr_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_advance,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W:0]   w_cand;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_cand = {1'b0, r_ptr} + (IDX_W+1)'(i);
            if (w_cand >= (IDX_W+1)'(NUM_REQ))
                w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
            if (!w_found && i_req[w_cand[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_idx   = w_cand[IDX_W-1:0];
            end
        end
    end

    assign o_any = w_found;
    assign o_idx = w_idx;
    assign o_gnt = w_found ? (NUM_REQ'(1) << w_idx) : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_advance && w_found) begin
            r_ptr <= (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_scheduler.sv
// One SPI mode-0 master shared by NUM_REQ requesters; each grant runs a fixed-length one-byte transfer.
module spi_master_scheduler
    import spi_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int NUM_SLAVES = 4,
    parameter int SEL_W      = 2,
    parameter int CLK_DIV    = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*SEL_W-1:0]        req_slave,
    input  logic [NUM_REQ*BYTE_W-1:0]       req_data,
    output logic [NUM_REQ-1:0]              gnt,
    output logic                            done,
    output logic [$clog2(NUM_REQ)-1:0]      done_id,
    output logic [BYTE_W-1:0]               rx_data,
    output logic                            err,
    output logic                            busy,
    output logic                            SCLK,
    output logic [NUM_SLAVES-1:0]           CS,
    output logic                            MOSI,
    input  logic                            MISO
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [2:0]            r_state;
    logic [NUM_REQ-1:0]    r_gnt;
    logic                  r_done;
    logic                  r_err;
    logic                  r_sclk;
    logic                  r_mosi;
    logic                  r_inval;
    logic [NUM_SLAVES-1:0] r_cs;
    logic [BYTE_W-1:0]     r_tx;
    logic [BYTE_W-1:0]     r_shift;
    logic [BYTE_W-1:0]     r_rx;
    logic [ID_W-1:0]       r_id;
    logic [ID_W-1:0]       r_done_id;
    logic [DIV_W-1:0]      r_div;
    logic [3:0]            r_half;

    logic [NUM_REQ-1:0]    w_arb_gnt;
    logic [ID_W-1:0]       w_arb_idx;
    logic                  w_arb_any;
    logic                  w_advance;
    logic [SEL_W-1:0]      w_sel;
    logic [BYTE_W-1:0]     w_data;
    logic                  w_inval;
    logic                  w_div_end;
    logic                  w_sample;

    assign w_advance = (r_state == ST_IDLE) && w_arb_any;

    spi_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_arb (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_req     (req),
        .i_advance (w_advance),
        .o_gnt     (w_arb_gnt),
        .o_idx     (w_arb_idx),
        .o_any     (w_arb_any)
    );

    assign w_sel     = req_slave[32'(w_arb_idx)*SEL_W +: SEL_W];
    assign w_data    = req_data[32'(w_arb_idx)*BYTE_W +: BYTE_W];
    assign w_inval   = (32'(w_sel) >= NUM_SLAVES);
    assign w_div_end = (r_div == DIV_W'(CLK_DIV - 1));
    // Leading SCLK edge samples MISO in mode 0; trailing edge shifts MOSI.
    assign w_sample  = (r_sclk == SPI_CPOL) ^ SPI_CPHA;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_sclk    <= SPI_CPOL;
            r_mosi    <= 1'b0;
            r_inval   <= 1'b0;
            r_cs      <= '1;
            r_tx      <= '0;
            r_shift   <= '0;
            r_rx      <= '0;
            r_id      <= '0;
            r_done_id <= '0;
            r_div     <= '0;
            r_half    <= '0;
        end else begin
            r_gnt  <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_any) begin
                        r_gnt   <= w_arb_gnt;
                        r_id    <= w_arb_idx;
                        r_tx    <= w_data;
                        r_mosi  <= w_data[BYTE_W-1];
                        r_inval <= w_inval;
                        r_cs    <= w_inval ? '1 : ~(NUM_SLAVES'(1) << w_sel);
                        r_div   <= '0;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_half  <= '0;
                        r_state <= ST_XFER;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                ST_XFER: begin
                    if (w_div_end) begin
                        r_div  <= '0;
                        r_sclk <= ~r_sclk;
                        r_half <= r_half + 1'b1;
                        if (w_sample) begin
                            r_shift <= {r_shift[BYTE_W-2:0], MISO};
                        end else if (r_half == 4'(2*BYTE_W - 1)) begin
                            r_state <= ST_HOLD;
                        end else begin
                            r_tx   <= {r_tx[BYTE_W-2:0], 1'b0};
                            r_mosi <= r_tx[BYTE_W-2];
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_cs    <= '1;
                        r_mosi  <= 1'b0;
                        r_state <= ST_DONE;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done    <= 1'b1;
                    r_err     <= r_inval;
                    r_rx      <= r_inval ? '0 : r_shift;
                    r_done_id <= r_id;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign done    = r_done;
    assign done_id = r_done_id;
    assign rx_data = r_rx;
    assign err     = r_err;
    // The done pulse lands in IDLE, so busy also covers that cycle.
    assign busy    = (r_state != ST_IDLE) || r_done;
    assign SCLK    = r_sclk;
    assign CS      = r_cs;
    assign MOSI    = r_mosi;

endmodule

// File: tb/tb_spi_master_scheduler.sv
// Bench for spi_master_scheduler: directed scenarios plus randomized transfers against a round-robin/SPI slave model.
module tb_spi_master_scheduler;

    localparam int NR  = 4;
    localparam int NS  = 3;
    localparam int SW  = 2;
    localparam int CD  = 2;
    localparam int LAT = 1 + CD * 18;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req;
    logic [NR*SW-1:0] req_slave;
    logic [NR*8-1:0] req_data;
    logic [NR-1:0]   gnt;
    logic            done;
    logic [1:0]      done_id;
    logic [7:0]      rx_data;
    logic            err;
    logic            busy;
    logic            SCLK;
    logic [NS-1:0]   CS;
    logic            MOSI;
    logic            MISO = 1'b0;

    int checks = 0;
    int errors = 0;
    int mptr = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;
    int cs_multi = 0;
    int cs_idle = 0;
    logic [7:0] mosi_sh = '0;
    logic [7:0] resp [0:NS-1];
    logic [NS-1:0] prev_cs = '1;
    logic [7:0] s_sh = '0;

    spi_master_scheduler #(
        .NUM_REQ    (NR),
        .NUM_SLAVES (NS),
        .SEL_W      (SW),
        .CLK_DIV    (CD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_slave (req_slave),
        .req_data  (req_data),
        .gnt       (gnt),
        .done      (done),
        .done_id   (done_id),
        .rx_data   (rx_data),
        .err       (err),
        .busy      (busy),
        .SCLK      (SCLK),
        .CS        (CS),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    always #5 clk = ~clk;

    // Mode-0 slave: loads its byte on select, presents MSB first, shifts on each falling SCLK.
    always @(CS or negedge SCLK) begin
        if (CS !== prev_cs) begin
            prev_cs = CS;
            s_sh = '0;
            for (int s = 0; s < NS; s++)
                if (CS === ~(NS'(1) << s)) s_sh = resp[s];
            MISO = s_sh[7];
        end else if (CS !== '1) begin
            s_sh = {s_sh[6:0], 1'b0};
            MISO = s_sh[7];
        end
    end

    always @(posedge SCLK) begin
        rise_cnt++;
        mosi_sh = {mosi_sh[6:0], MOSI};
    end

    always @(negedge SCLK) fall_cnt++;

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if ($countones(~CS) > 1) cs_multi++;
            if (CS !== '1 && busy !== 1'b1) cs_idle++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pick(input logic [NR-1:0] m, output int w);
        w = -1;
        for (int k = 0; k < NR; k++)
            if (w < 0 && m[(mptr + k) % NR]) w = (mptr + k) % NR;
        if (w >= 0) mptr = (w + 1) % NR;
    endtask

    task automatic set_req(input int id, input logic [1:0] sl, input logic [7:0] dt);
        req_slave[id*SW +: SW] = sl;
        req_data[id*8 +: 8]    = dt;
    endtask

    task automatic reset_dut(input string tag);
        reset = 1'b0;
        req   = '0;
        repeat (3) @(negedge clk);
        chk({tag, "_sclk"}, 32'(SCLK), 0);
        chk({tag, "_cs"}, 32'(CS), 32'(3'b111));
        chk({tag, "_mosi"}, 32'(MOSI), 0);
        chk({tag, "_gnt"}, 32'(gnt), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_rx"}, 32'(rx_data), 0);
        chk({tag, "_done_id"}, 32'(done_id), 0);
        reset = 1'b1;
        mptr  = 0;
        @(negedge clk);
    endtask

    task automatic do_xfer(input string tag, input int id, input logic [1:0] sl,
                           input logic [7:0] dt, input bit drop, input int pulse_id,
                           output int gap);
        int n;
        int lat;
        int r0;
        int f0;
        int busy_low;
        int extra;
        logic [NS-1:0] cs_or;
        bit inval;
        logic [7:0] exp_rx;
        logic [NS-1:0] exp_cs;
        inval  = (sl >= NS);
        exp_rx = inval ? 8'h00 : resp[sl];
        exp_cs = inval ? '0 : (NS'(1) << sl);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt === '0 && n < 300);
        gap = n;
        chk({tag, "_gnt"}, 32'(gnt), 32'(1) << id);
        r0 = rise_cnt;
        f0 = fall_cnt;
        cs_or = ~CS;
        busy_low = (busy === 1'b1) ? 0 : 1;
        extra = 0;
        if (drop) begin
            req       = '0;
            req_slave = NR*SW'($urandom);
            req_data  = $urandom;
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            cs_or = cs_or | ~CS;
            if (busy !== 1'b1) busy_low++;
            if (gnt !== '0) extra++;
            if (pulse_id >= 0 && lat == 10) req[pulse_id] = 1'b1;
            if (pulse_id >= 0 && lat == 11) req[pulse_id] = 1'b0;
        end while (done !== 1'b1 && lat < 100);
        chk({tag, "_latency"}, 32'(lat), 32'(LAT));
        chk({tag, "_done_id"}, 32'(done_id), 32'(id));
        chk({tag, "_rx"}, 32'(rx_data), 32'(exp_rx));
        chk({tag, "_err"}, 32'(err), 32'(inval));
        chk({tag, "_rises"}, 32'(rise_cnt - r0), 8);
        chk({tag, "_falls"}, 32'(fall_cnt - f0), 8);
        chk({tag, "_mosi"}, 32'(mosi_sh), 32'(dt));
        chk({tag, "_cs_used"}, 32'(cs_or), 32'(exp_cs));
        chk({tag, "_cs_done"}, 32'(CS), 32'(3'b111));
        chk({tag, "_busy_low"}, 32'(busy_low), 0);
        chk({tag, "_extra_gnt"}, 32'(extra), 0);
    endtask

    initial begin
        int w;
        int gap;
        int n;
        int r0;
        int dn;
        logic [1:0] sl_a [0:NR-1];
        logic [7:0] dt_a [0:NR-1];
        logic [NR-1:0] mask;

        for (int s = 0; s < NS; s++) resp[s] = 8'($urandom);
        resp[1]   = 8'hCA;
        reset     = 1'b0;
        req       = '0;
        req_slave = '0;
        req_data  = '0;

        reset_dut("rst0");

        set_req(0, 2'd1, 8'hB5);
        req = 4'b0001;
        pick(req, w);
        do_xfer("single", w, 2'd1, 8'hB5, 1'b1, -1, gap);

        for (int r = 0; r < NR; r++) begin
            sl_a[r] = 2'($urandom_range(0, NS - 1));
            dt_a[r] = 8'($urandom);
        end
        set_req(2, sl_a[2], dt_a[2]);
        req = 4'b0100;
        pick(req, w);
        do_xfer("wrap_a", w, sl_a[w], dt_a[w], 1'b1, -1, gap);
        set_req(3, sl_a[3], dt_a[3]);
        req = 4'b1000;
        pick(req, w);
        do_xfer("wrap_b", w, sl_a[w], dt_a[w], 1'b1, -1, gap);
        set_req(0, sl_a[0], dt_a[0]);
        set_req(3, sl_a[3], dt_a[3]);
        req = 4'b1001;
        pick(req, w);
        chk("wrap_first_is_0", 32'(w), 0);
        do_xfer("wrap_c", w, sl_a[w], dt_a[w], 1'b0, -1, gap);
        pick(req, w);
        do_xfer("wrap_d", w, sl_a[w], dt_a[w], 1'b1, -1, gap);

        set_req(1, 2'd3, 8'h5A);
        req = 4'b0010;
        pick(req, w);
        do_xfer("invalid", w, 2'd3, 8'h5A, 1'b1, -1, gap);

        set_req(0, sl_a[0], dt_a[0]);
        req = 4'b0001;
        pick(req, w);
        do_xfer("withdrawn", w, sl_a[0], dt_a[0], 1'b1, 3, gap);
        n = 0;
        repeat (60) begin
            @(negedge clk);
            if (gnt !== '0 || CS !== '1) n++;
        end
        chk("withdrawn_quiet", 32'(n), 0);

        // Abort: reset lands after the fourth rising SCLK edge.
        set_req(2, sl_a[2], 8'h83);
        req = 4'b0100;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt === '0 && n < 50);
        chk("abort_gnt", 32'(gnt), 32'(4'b0100));
        req = '0;
        r0 = rise_cnt;
        n = 0;
        while (rise_cnt - r0 < 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("abort_rises", 32'(rise_cnt - r0), 4);
        reset = 1'b0;
        #1;
        chk("abort_cs", 32'(CS), 32'(3'b111));
        chk("abort_sclk", 32'(SCLK), 0);
        chk("abort_mosi", 32'(MOSI), 0);
        chk("abort_busy", 32'(busy), 0);
        dn = 0;
        repeat (4) begin
            @(negedge clk);
            if (done !== 1'b0) dn++;
        end
        reset = 1'b1;
        mptr  = 0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0) dn++;
        end
        chk("abort_no_done", 32'(dn), 0);
        set_req(2, sl_a[2], 8'h83);
        req = 4'b0100;
        pick(req, w);
        do_xfer("after_abort", w, sl_a[2], 8'h83, 1'b1, -1, gap);

        reset_dut("rst1");
        dt_a[0] = 8'hF0;
        dt_a[1] = 8'hCC;
        dt_a[2] = 8'hAA;
        dt_a[3] = 8'h53;
        for (int r = 0; r < NR; r++) begin
            sl_a[r] = 2'($urandom_range(0, NS - 1));
            set_req(r, sl_a[r], dt_a[r]);
        end
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            pick(req, w);
            chk("rr_order", 32'(w), 32'(t % NR));
            do_xfer("rr", w, sl_a[w], dt_a[w], 1'b0, -1, gap);
            if (t > 0) chk("rr_gap", 32'(gap), 1);
        end
        req = '0;
        @(negedge clk);

        for (int it = 0; it < 8; it++) begin
            mask = 4'($urandom_range(1, 15));
            for (int r = 0; r < NR; r++) begin
                sl_a[r] = 2'($urandom_range(0, 3));
                dt_a[r] = 8'($urandom);
                set_req(r, sl_a[r], dt_a[r]);
            end
            req = mask;
            pick(req, w);
            do_xfer("rand", w, sl_a[w], dt_a[w], 1'b1, -1, gap);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        chk("cs_one_hot", 32'(cs_multi), 0);
        chk("cs_idle", 32'(cs_idle), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
